// File: rtl/rv32_pkg.sv
// Shared rv32 memory-port constants and the HTIF bridge state encoding.
package rv32_pkg;

   localparam logic [2:0] MT_X  = 3'd0;
   localparam logic [2:0] MT_B  = 3'd1;
   localparam logic [2:0] MT_H  = 3'd2;
   localparam logic [2:0] MT_W  = 3'd3;
   localparam logic [2:0] MT_D  = 3'd4;
   localparam logic [2:0] MT_BU = 3'd5;
   localparam logic [2:0] MT_HU = 3'd6;
   localparam logic [2:0] MT_WU = 3'd7;

   localparam logic M_XRD = 1'b0;
   localparam logic M_XWR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LO_REQ,
      LO_WAIT,
      HI_REQ,
      HI_WAIT,
      REPLY
   } bridge_state_e;

endpackage

// File: rtl/htif_mem_bridge_if.sv
// HTIF host port plus 32-bit data-memory port; master = bridge side, slave = host/memory side.
interface htif_mem_bridge_if #(
   parameter int HTIF_AW = 64,
   parameter int MEM_AW  = 32
);
   logic               htif_req_valid;
   logic               htif_req_ready;
   logic               htif_req_rw;
   logic [HTIF_AW-1:0] htif_req_addr;
   logic [63:0]        htif_req_data;
   logic               htif_rep_valid;
   logic [63:0]        htif_rep_bits;
   logic               mem_req_valid;
   logic               mem_req_ready;
   logic [MEM_AW-1:0]  mem_req_addr;
   logic [31:0]        mem_req_data;
   logic               mem_req_fcn;
   logic [2:0]         mem_req_typ;
   logic               mem_resp_valid;
   logic [31:0]        mem_resp_data;

   modport master (
      input  htif_req_valid, htif_req_rw, htif_req_addr, htif_req_data,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output htif_req_ready, htif_rep_valid, htif_rep_bits,
      output mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ
   );

   modport slave (
      output htif_req_valid, htif_req_rw, htif_req_addr, htif_req_data,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  htif_req_ready, htif_rep_valid, htif_rep_bits,
      input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ
   );
endinterface

// File: rtl/htif_beat_ctr.sv
// Per-beat watchdog counter: clear on state entry, count while enabled, flag at LIMIT.
module htif_beat_ctr #(
   parameter int W     = 8,
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   logic [W-1:0] cnt;

   assign expire = (cnt == W'(LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt <= '0;
      else if (clr)            cnt <= '0;
      else if (en && !expire)  cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/htif_mem_bridge.sv
// Splits 64-bit HTIF requests into two 32-bit memory beats (low word first).
// Optional per-beat watchdog enabled by HTIF_MEM_BRIDGE_TIMEOUT_EN.
module htif_mem_bridge
   import rv32_pkg::*;
#(
   parameter int HTIF_AW     = 64,
   parameter int MEM_AW      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   htif_mem_bridge_if.master  bus,
   output logic               busy,
   output logic               timeout_err
);
   bridge_state_e     state, next_state;
   logic              rw_q;
   logic [MEM_AW-4:0] base_q;
   logic [63:0]       wdata_q;
   logic [31:0]       lo_q, hi_q;
   logic              expire_act;
   logic              to_hit_q;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{bus.htif_req_addr[HTIF_AW-1:MEM_AW], bus.htif_req_addr[2:0]};

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (bus.htif_req_valid) next_state = LO_REQ;
         LO_REQ:  if (bus.mem_req_ready)  next_state = LO_WAIT;
         LO_WAIT: if (bus.mem_resp_valid) next_state = HI_REQ;
         HI_REQ:  if (bus.mem_req_ready)  next_state = HI_WAIT;
         HI_WAIT: if (bus.mem_resp_valid) next_state = REPLY;
         REPLY:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (expire_act) next_state = REPLY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rw_q    <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && bus.htif_req_valid) begin
            rw_q    <= bus.htif_req_rw;
            base_q  <= bus.htif_req_addr[MEM_AW-1:3];
            wdata_q <= bus.htif_req_data;
         end
         if (state == LO_WAIT && bus.mem_resp_valid && rw_q == M_XRD) lo_q <= bus.mem_resp_data;
         if (state == HI_WAIT && bus.mem_resp_valid && rw_q == M_XRD) hi_q <= bus.mem_resp_data;
      end
   end

   // All memory-side outputs decode from state, so no host->memory combinational path exists.
   always_comb begin
      bus.htif_req_ready = 1'b0;
      bus.htif_rep_valid = 1'b0;
      bus.htif_rep_bits  = '0;
      bus.mem_req_valid  = 1'b0;
      bus.mem_req_addr   = '0;
      bus.mem_req_data   = '0;
      bus.mem_req_fcn    = M_XRD;
      bus.mem_req_typ    = MT_W;
      busy               = 1'b1;
      unique case (state)
         IDLE: begin
            bus.htif_req_ready = 1'b1;
            busy               = 1'b0;
         end
         LO_REQ: begin
            bus.mem_req_valid = !expire_act;
            bus.mem_req_addr  = {base_q, 3'b000};
            bus.mem_req_data  = wdata_q[31:0];
            bus.mem_req_fcn   = rw_q;
         end
         HI_REQ: begin
            bus.mem_req_valid = !expire_act;
            bus.mem_req_addr  = {base_q, 3'b100};
            bus.mem_req_data  = wdata_q[63:32];
            bus.mem_req_fcn   = rw_q;
         end
         REPLY: begin
            bus.htif_rep_valid = 1'b1;
            if (to_hit_q)            bus.htif_rep_bits = 64'hDEAD_BEEF_DEAD_BEEF;
            else if (rw_q == M_XRD)  bus.htif_rep_bits = {hi_q, lo_q};
         end
         default: ;
      endcase
   end

`ifdef HTIF_MEM_BRIDGE_TIMEOUT_EN
   localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
   localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

   logic in_beat, ctr_clr, ctr_expire, err_q;

   assign in_beat = (state == LO_REQ) || (state == LO_WAIT) ||
                    (state == HI_REQ) || (state == HI_WAIT);
   // Clearing on any state change zeroes the count for the first cycle of the new state.
   assign ctr_clr    = (next_state != state);
   assign expire_act = ctr_expire && in_beat;

   htif_beat_ctr #(.W(CW), .LIMIT(TIMEOUT_CYC)) u_beat_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (ctr_clr),
      .en     (in_beat),
      .expire (ctr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_hit_q <= 1'b0;
         err_q    <= 1'b0;
      end else if (expire_act) begin
         to_hit_q <= 1'b1;
         err_q    <= 1'b1;
      end else if (state == IDLE) begin
         to_hit_q <= 1'b0;
      end
   end

   assign timeout_err = err_q;
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
   assign expire_act  = 1'b0;
   assign to_hit_q    = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
